// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file writeback path and load scoreboard.
package regfile_pkg;

  localparam int XLEN        = 32;
  localparam int NREG        = 32;
  localparam int REG_ADDR_W  = $clog2(NREG);
  localparam int MAX_PENDING = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_HELD
  } hold_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding loads, outstanding-load counter and the
// issue stall that protects against RAW/WAW hazards on those loads.
module regfile_scoreboard #(
  parameter int NREG        = 32,
  parameter int MAX_PENDING = 4,
  localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_issue_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_rs1,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_rs2,
  input  logic                              i_use_rs1,
  input  logic                              i_use_rs2,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_rd,
  input  logic                              i_wren,
  input  logic                              i_is_load,
  input  logic                              i_clr_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_clr_rd,
  output logic                              o_stall,
  output logic [NREG-1:0]                   o_busy,
  output logic [PEND_W-1:0]                 o_pending
);
  import regfile_pkg::*;

  logic [NREG-1:0]   busy, busy_nxt;
  logic [PEND_W-1:0] pending;
  logic              full, set_en, clr_en;

  assign full = (pending == PEND_W'(MAX_PENDING));

  assign o_stall = i_issue_valid &
                   ((i_use_rs1 & busy[i_rs1]) |
                    (i_use_rs2 & busy[i_rs2]) |
                    (i_wren    & busy[i_rd])  |
                    (i_is_load & i_wren & (i_rd != '0) & full));

  assign set_en = i_issue_valid & ~o_stall & i_is_load & i_wren & (i_rd != '0);
  // A write for a register that is no longer busy (e.g. a return that outlived a
  // reset) is committed by the top but must not disturb the counter.
  assign clr_en = i_clr_valid & busy[i_clr_rd];

  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[i_clr_rd] = 1'b0;
    if (set_en) busy_nxt[i_rd]     = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy <= busy_nxt;
      case ({set_en, clr_en})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  assign o_busy    = busy;
  assign o_pending = pending;

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Shares the single register file write port between ALU writeback and load
// returns (ALU first, one-entry hold buffer for a displaced load) and scoreboards loads.
module regfile_wb_scoreboard #(
  parameter int XLEN        = regfile_pkg::XLEN,
  parameter int NREG        = regfile_pkg::NREG,
  parameter int MAX_PENDING = regfile_pkg::MAX_PENDING,
  localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_issue_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_issue_rs1,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_issue_rs2,
  input  logic                              i_issue_use_rs1,
  input  logic                              i_issue_use_rs2,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_issue_rd,
  input  logic                              i_issue_wren,
  input  logic                              i_issue_is_load,
  output logic                              o_issue_stall,
  input  logic                              i_alu_wb_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_alu_wb_rd,
  input  logic [XLEN-1:0]                   i_alu_wb_data,
  input  logic                              i_lsu_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]                   i_lsu_data,
  output logic                              o_lsu_ready,
  output logic                              o_rd_wren,
  output logic [regfile_pkg::REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]                   o_rd_data,
  output logic [PEND_W-1:0]                 o_pending_loads
);
  import regfile_pkg::*;

  hold_state_e     state;
  wb_req_t         held;
  logic            out_is_load;
  logic [NREG-1:0] busy;
  logic            alu_v, lsu_acc, lsu_v;

  // Writes to x0 are dropped at the door so they never take the write port.
  assign alu_v       = i_alu_wb_valid & (i_alu_wb_rd != '0);
  assign o_lsu_ready = (state == HOLD_EMPTY);
  assign lsu_acc     = i_lsu_valid & o_lsu_ready;
  assign lsu_v       = lsu_acc & (i_lsu_rd != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= HOLD_EMPTY;
      held        <= '0;
      o_rd_wren   <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_data   <= '0;
      out_is_load <= 1'b0;
    end else begin
      o_rd_wren   <= 1'b0;
      out_is_load <= 1'b0;
      if (alu_v) begin
        o_rd_wren <= 1'b1;
        o_rd_addr <= i_alu_wb_rd;
        o_rd_data <= i_alu_wb_data;
      end else if (state == HOLD_HELD) begin
        o_rd_wren   <= 1'b1;
        o_rd_addr   <= held.rd;
        o_rd_data   <= held.data;
        out_is_load <= 1'b1;
      end else if (lsu_v) begin
        o_rd_wren   <= 1'b1;
        o_rd_addr   <= i_lsu_rd;
        o_rd_data   <= i_lsu_data;
        out_is_load <= 1'b1;
      end

      case (state)
        HOLD_EMPTY: if (lsu_v && alu_v) begin
          held  <= '{rd: i_lsu_rd, data: i_lsu_data};
          state <= HOLD_HELD;
        end
        HOLD_HELD:  if (!alu_v) state <= HOLD_EMPTY;
        default:    state <= HOLD_EMPTY;
      endcase
    end
  end

  // Busy bit is released when the load's write is on the port; the register file
  // commits on that same edge, so dependents see the data one cycle later.
  regfile_scoreboard #(
    .NREG        (NREG),
    .MAX_PENDING (MAX_PENDING)
  ) u_sb (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_issue_valid (i_issue_valid),
    .i_rs1         (i_issue_rs1),
    .i_rs2         (i_issue_rs2),
    .i_use_rs1     (i_issue_use_rs1),
    .i_use_rs2     (i_issue_use_rs2),
    .i_rd          (i_issue_rd),
    .i_wren        (i_issue_wren),
    .i_is_load     (i_issue_is_load),
    .i_clr_valid   (o_rd_wren & out_is_load),
    .i_clr_rd      (o_rd_addr),
    .o_stall       (o_issue_stall),
    .o_busy        (busy),
    .o_pending     (o_pending_loads)
  );

  a_alu_wb_to_busy: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_alu_wb_valid && (i_alu_wb_rd != '0) && busy[i_alu_wb_rd]));

  a_load_to_idle: assert property (@(posedge i_clk) disable iff (i_reset)
    !(lsu_acc && (i_lsu_rd != '0) && !busy[i_lsu_rd]));

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: stall vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_regfile_wb_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_issue_valid, i_issue_use_rs1, i_issue_use_rs2, i_issue_wren, i_issue_is_load;
  logic [4:0]  i_issue_rs1, i_issue_rs2, i_issue_rd;
  logic        o_issue_stall;
  logic        i_alu_wb_valid;
  logic [4:0]  i_alu_wb_rd;
  logic [31:0] i_alu_wb_data;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        o_lsu_ready;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [2:0]  o_pending_loads;

  int total = 0;
  int bad   = 0;

  regfile_wb_scoreboard dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_issue_valid(i_issue_valid), .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
    .i_issue_use_rs1(i_issue_use_rs1), .i_issue_use_rs2(i_issue_use_rs2),
    .i_issue_rd(i_issue_rd), .i_issue_wren(i_issue_wren), .i_issue_is_load(i_issue_is_load),
    .o_issue_stall(o_issue_stall),
    .i_alu_wb_valid(i_alu_wb_valid), .i_alu_wb_rd(i_alu_wb_rd), .i_alu_wb_data(i_alu_wb_data),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .o_lsu_ready(o_lsu_ready),
    .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .o_pending_loads(o_pending_loads)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld;
    logic       stall;
  } vec_t;
  vec_t tbl[10];

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  // reference model state
  bit [31:0]  mbusy;
  ent_t       q[$];
  logic [4:0] outst[$];
  logic       cur_wr, cur_ld;
  logic [4:0] cur_addr;
  logic [31:0] cur_data;
  logic       exp_stall, acc, alu_v;
  logic [4:0] r_rs1, r_rs2, r_rd, r_pick;
  logic       r_v, r_u1, r_u2, r_wr, r_ld;
  ent_t       e;
  int         idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_issue_valid = 0; i_issue_rs1 = 0; i_issue_rs2 = 0; i_issue_use_rs1 = 0;
    i_issue_use_rs2 = 0; i_issue_rd = 0; i_issue_wren = 0; i_issue_is_load = 0;
    i_alu_wb_valid = 0; i_alu_wb_rd = 0; i_alu_wb_data = 0;
    i_lsu_valid = 0; i_lsu_rd = 0; i_lsu_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
    i_issue_valid = 1; i_issue_rs1 = rs1; i_issue_rs2 = rs2; i_issue_use_rs1 = u1;
    i_issue_use_rs2 = u2; i_issue_rd = rd; i_issue_wren = wr; i_issue_is_load = ld;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    i_alu_wb_valid = 1; i_alu_wb_rd = rd; i_alu_wb_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    i_lsu_valid = 1; i_lsu_rd = rd; i_lsu_data = d;
  endtask

  initial begin
    //          v  rs1 rs2 u1 u2 rd wr ld stall   (busy: x5, x9; pending 2)
    tbl[0] = '{1, 5,  0,  1, 0, 8, 1, 0, 1};
    tbl[1] = '{1, 5,  0,  0, 0, 8, 1, 0, 0};
    tbl[2] = '{1, 0,  9,  0, 1, 8, 1, 0, 1};
    tbl[3] = '{1, 9,  9,  0, 0, 8, 1, 0, 0};
    tbl[4] = '{1, 1,  2,  1, 1, 5, 1, 0, 1};
    tbl[5] = '{1, 1,  2,  1, 1, 5, 0, 0, 0};
    tbl[6] = '{1, 1,  2,  1, 1, 9, 1, 1, 1};
    tbl[7] = '{1, 0,  0,  1, 1, 0, 1, 1, 0};
    tbl[8] = '{1, 6,  7,  1, 1, 8, 1, 1, 0};
    tbl[9] = '{0, 5,  9,  1, 1, 5, 1, 1, 0};

    idle();
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_wren", 32'(o_rd_wren), 0);
    chk("rst_addr", 32'(o_rd_addr), 0);
    chk("rst_data", o_rd_data, 0);
    chk("rst_ready", 32'(o_lsu_ready), 1);
    chk("rst_pending", 32'(o_pending_loads), 0);
    i_reset = 0;
    issue(5, 0, 1, 0, 0, 0, 0);
    #1 chk("rst_stall", 32'(o_issue_stall), 0);
    idle();
    tick();

    // stall vector table
    issue(0, 0, 0, 0, 5, 1, 1); tick();
    issue(0, 0, 0, 0, 9, 1, 1); tick();
    idle();
    chk("tbl_pending", 32'(o_pending_loads), 2);
    for (int i = 0; i < 10; i++) begin
      i_issue_valid = tbl[i].v; i_issue_rs1 = tbl[i].rs1; i_issue_rs2 = tbl[i].rs2;
      i_issue_use_rs1 = tbl[i].u1; i_issue_use_rs2 = tbl[i].u2; i_issue_rd = tbl[i].rd;
      i_issue_wren = tbl[i].wr; i_issue_is_load = tbl[i].ld;
      #1 chk($sformatf("tbl_stall[%0d]", i), 32'(o_issue_stall), 32'(tbl[i].stall));
    end
    idle();
    lsu(5, 32'h5); tick();
    lsu(9, 32'h9); tick();
    idle(); tick(); tick();
    chk("tbl_drain_pending", 32'(o_pending_loads), 0);

    // RAW stall and release timing
    issue(0, 0, 0, 0, 5, 1, 1);
    #1 chk("raw_load_stall", 32'(o_issue_stall), 0);
    tick();
    issue(5, 0, 1, 0, 8, 1, 0);
    #1 chk("raw_stall", 32'(o_issue_stall), 1);
    tick();
    lsu(5, 32'hDEADBEEF);
    #1 chk("raw_stall_ret", 32'(o_issue_stall), 1);
    tick();
    i_lsu_valid = 0;
    chk("raw_wren", 32'(o_rd_wren), 1);
    chk("raw_addr", 32'(o_rd_addr), 5);
    chk("raw_data", o_rd_data, 32'hDEADBEEF);
    #1 chk("raw_stall_wb", 32'(o_issue_stall), 1);
    tick();
    chk("raw_stall_drop", 32'(o_issue_stall), 0);
    chk("raw_pending", 32'(o_pending_loads), 0);
    tick();
    idle();

    // ALU / load collision
    issue(0, 0, 0, 0, 7, 1, 1); tick();
    idle();
    alu(3, 32'h11); lsu(7, 32'h22);
    #1 chk("col_ready0", 32'(o_lsu_ready), 1);
    tick();
    idle();
    chk("col_wren1", 32'(o_rd_wren), 1);
    chk("col_addr1", 32'(o_rd_addr), 3);
    chk("col_data1", o_rd_data, 32'h11);
    chk("col_ready1", 32'(o_lsu_ready), 0);
    tick();
    chk("col_wren2", 32'(o_rd_wren), 1);
    chk("col_addr2", 32'(o_rd_addr), 7);
    chk("col_data2", o_rd_data, 32'h22);
    chk("col_ready2", 32'(o_lsu_ready), 1);
    tick();
    chk("col_wren3", 32'(o_rd_wren), 0);
    chk("col_pending", 32'(o_pending_loads), 0);

    // sustained ALU writeback while a load is held
    issue(0, 0, 0, 0, 9, 1, 1); tick();
    idle();
    alu(10, 32'hA0); lsu(9, 32'h99); tick();
    for (int k = 1; k <= 3; k++) begin
      alu(5'(10 + k), 32'hA0 + 32'(k)); lsu(20, 32'hBAD);
      chk($sformatf("hold_wr_alu%0d", k), 32'(o_rd_addr), 32'(10 + k - 1));
      chk($sformatf("hold_ready%0d", k), 32'(o_lsu_ready), 0);
      tick();
    end
    i_alu_wb_valid = 0;
    chk("hold_last_alu", 32'(o_rd_addr), 13);
    #1 chk("hold_ready4", 32'(o_lsu_ready), 0);
    tick();
    i_lsu_valid = 0;
    chk("hold_drain_wren", 32'(o_rd_wren), 1);
    chk("hold_drain_addr", 32'(o_rd_addr), 9);
    chk("hold_drain_data", o_rd_data, 32'h99);
    chk("hold_ready_back", 32'(o_lsu_ready), 1);
    tick();
    chk("hold_idle_wren", 32'(o_rd_wren), 0);
    chk("hold_pending", 32'(o_pending_loads), 0);

    // pending limit
    for (int r = 1; r <= 4; r++) begin
      issue(0, 0, 0, 0, 5'(r), 1, 1);
      #1 chk($sformatf("lim_issue%0d", r), 32'(o_issue_stall), 0);
      tick();
    end
    idle();
    chk("lim_pending4", 32'(o_pending_loads), 4);
    issue(0, 0, 0, 0, 6, 1, 1);
    #1 chk("lim_stall", 32'(o_issue_stall), 1);
    lsu(1, 32'h1); tick();
    i_lsu_valid = 0;
    chk("lim_ret_addr", 32'(o_rd_addr), 1);
    #1 chk("lim_stall_wb", 32'(o_issue_stall), 1);
    tick();
    chk("lim_pending3", 32'(o_pending_loads), 3);
    chk("lim_stall_free", 32'(o_issue_stall), 0);
    tick();
    idle();
    chk("lim_pending_re4", 32'(o_pending_loads), 4);
    lsu(2, 32'h2); tick();
    lsu(3, 32'h3); tick();
    lsu(4, 32'h4); tick();
    lsu(6, 32'h6); tick();
    idle(); tick();
    chk("lim_drained", 32'(o_pending_loads), 0);

    // x0 handling
    issue(0, 0, 0, 0, 0, 1, 1);
    #1 chk("x0_stall", 32'(o_issue_stall), 0);
    tick();
    idle();
    chk("x0_pending", 32'(o_pending_loads), 0);
    alu(0, 32'h55); tick();
    idle();
    chk("x0_alu_wren", 32'(o_rd_wren), 0);
    lsu(0, 32'h66);
    #1 chk("x0_ready", 32'(o_lsu_ready), 1);
    tick();
    idle();
    chk("x0_lsu_wren", 32'(o_rd_wren), 0);

    // reset while a load is held
    issue(0, 0, 0, 0, 5, 1, 1); tick();
    idle();
    alu(3, 32'h33); lsu(5, 32'h55); tick();
    idle();
    chk("mid_held", 32'(o_lsu_ready), 0);
    chk("mid_pending", 32'(o_pending_loads), 1);
    i_reset = 1;
    #1;
    chk("mid_rst_wren", 32'(o_rd_wren), 0);
    chk("mid_rst_ready", 32'(o_lsu_ready), 1);
    chk("mid_rst_pending", 32'(o_pending_loads), 0);
    issue(5, 0, 1, 0, 9, 0, 0);
    #1 chk("mid_rst_stall", 32'(o_issue_stall), 0);
    tick();
    chk("mid_rst_wren2", 32'(o_rd_wren), 0);
    i_reset = 0;
    idle();
    tick();
    chk("mid_no_drain", 32'(o_rd_wren), 0);

    // randomized run against the reference model
    mbusy = '0; cur_wr = 0; cur_ld = 0; cur_addr = 0; cur_data = 0;
    for (int c = 0; c < 3000; c++) begin
      r_v = 1'($urandom % 2); r_rs1 = 5'($urandom % 8); r_rs2 = 5'($urandom % 8);
      r_u1 = 1'($urandom % 2); r_u2 = 1'($urandom % 2); r_rd = 5'($urandom % 8);
      r_wr = ($urandom % 4) != 0; r_ld = ($urandom % 3) == 0;
      i_issue_valid = r_v; i_issue_rs1 = r_rs1; i_issue_rs2 = r_rs2; i_issue_use_rs1 = r_u1;
      i_issue_use_rs2 = r_u2; i_issue_rd = r_rd; i_issue_wren = r_wr; i_issue_is_load = r_ld;
      exp_stall = r_v && ((r_u1 && mbusy[r_rs1]) || (r_u2 && mbusy[r_rs2]) ||
                          (r_wr && mbusy[r_rd]) ||
                          (r_ld && r_wr && r_rd != 0 && $countones(mbusy) == 4));

      i_alu_wb_valid = 0;
      if ($urandom % 3 == 0) begin
        r_pick = 5'(1 + $urandom % 7);
        if (!mbusy[r_pick]) alu(r_pick, $urandom);
      end

      i_lsu_valid = 0;
      if (q.size() == 0 && outst.size() > 0 && ($urandom % 2) == 1) begin
        idx = int'($urandom % outst.size());
        lsu(outst[idx], $urandom);
        outst.delete(idx);
      end else if (q.size() != 0 && ($urandom % 4) == 0) begin
        lsu(5'($urandom % 32), $urandom);
      end

      #1;
      chk("rnd_stall", 32'(o_issue_stall), 32'(exp_stall));
      chk("rnd_ready", 32'(o_lsu_ready), 32'(q.size() == 0));

      acc = r_v && !exp_stall;
      if (cur_wr && cur_ld && mbusy[cur_addr]) mbusy[cur_addr] = 0;
      if (acc && r_ld && r_wr && r_rd != 0) begin
        mbusy[r_rd] = 1;
        outst.push_back(r_rd);
      end
      if (i_lsu_valid && q.size() == 0 && i_lsu_rd != 0) q.push_back('{i_lsu_rd, i_lsu_data});
      alu_v = i_alu_wb_valid && i_alu_wb_rd != 0;
      if (alu_v) begin
        cur_wr = 1; cur_ld = 0; cur_addr = i_alu_wb_rd; cur_data = i_alu_wb_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        cur_wr = 1; cur_ld = 1; cur_addr = e.rd; cur_data = e.data;
      end else begin
        cur_wr = 0; cur_ld = 0;
      end

      tick();
      chk("rnd_wren", 32'(o_rd_wren), 32'(cur_wr));
      if (cur_wr) begin
        chk("rnd_addr", 32'(o_rd_addr), 32'(cur_addr));
        chk("rnd_data", o_rd_data, cur_data);
      end
      chk("rnd_pending", 32'(o_pending_loads), 32'($countones(mbusy)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
